// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake and a two-entry skid buffer.
// in_ready comes straight from the state register, so ready never ripples between stages.
`timescale 1ns/1ps

module pipe_stage_skid #(
  parameter int unsigned           DATA_WIDTH = 16,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            occupancy
);

  localparam logic [1:0] StEmpty = 2'd0;
  localparam logic [1:0] StOne   = 2'd1;
  localparam logic [1:0] StFull  = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] main_q, main_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;
  logic                  in_fire, out_fire;

  assign in_ready  = (state_q != StFull);
  assign out_valid = (state_q != StEmpty);
  assign out_data  = main_q;
  assign occupancy = state_q;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    // Flush empties the stage but leaves both data registers untouched.
    if (flush) begin
      state_d = StEmpty;
    end else begin
      case (state_q)
        StEmpty: begin
          if (in_fire) begin
            state_d = StOne;
            main_d  = in_data;
          end
        end
        StOne: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire) begin
            state_d = StFull;
            skid_d  = in_data;
          end else if (out_fire) begin
            state_d = StEmpty;
          end
        end
        StFull: begin
          if (out_fire) begin
            state_d = StOne;
            main_d  = skid_q;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      main_q  <= RESET_VAL;
      skid_q  <= RESET_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: 8/16/32-bit instances share one handshake stream.
`timescale 1ns/1ps

module tb_pipe_stage_skid;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_data = '0;

  logic        in_ready8, in_ready16, in_ready32;
  logic        out_valid8, out_valid16, out_valid32;
  logic [7:0]  out_data8;
  logic [15:0] out_data16;
  logic [31:0] out_data32;
  logic [1:0]  occ8, occ16, occ32;

  logic [31:0] sb_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  bit          mon_en = 1'b0;

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_WIDTH(8), .RESET_VAL(8'h5A)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready8), .in_data(in_data[7:0]),
    .out_valid(out_valid8), .out_ready(out_ready), .out_data(out_data8),
    .occupancy(occ8)
  );

  pipe_stage_skid #(.DATA_WIDTH(16), .RESET_VAL(16'hDEAD)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready16), .in_data(in_data[15:0]),
    .out_valid(out_valid16), .out_ready(out_ready), .out_data(out_data16),
    .occupancy(occ16)
  );

  pipe_stage_skid #(.DATA_WIDTH(32), .RESET_VAL(32'hCAFEF00D)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready32), .in_data(in_data),
    .out_valid(out_valid32), .out_ready(out_ready), .out_data(out_data32),
    .occupancy(occ32)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // One handshake cycle; the accepted beat is queued from the model's own occupancy.
  task automatic cycle(input logic iv, input logic [31:0] d, input logic ordy, input logic fl);
    logic acc;
    @(negedge clk);
    #1;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    acc = iv && (sb_q.size() < 2);
    @(posedge clk);
    #1;
    if (fl) sb_q.delete();
    else if (acc) sb_q.push_back(d);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_occ16", {30'b0, occ16}, 32'd0);
    chk("rst_valid16", {31'b0, out_valid16}, 32'd0);
    chk("rst_ready16", {31'b0, in_ready16}, 32'd1);
    chk("rst_data16", {16'b0, out_data16}, 32'h0000DEAD);
    chk("rst_data8", {24'b0, out_data8}, 32'h0000005A);
    chk("rst_data32", out_data32, 32'hCAFEF00D);
    chk("rst_occ32", {30'b0, occ32}, 32'd0);
    sb_q.delete();
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;
  endtask

  // Monitor: samples mid-low-phase, checks control against the queue, pops on out_fire.
  always begin
    int          sz;
    logic [31:0] q0;
    @(negedge clk);
    #2;
    if (mon_en && rst_n) begin
      sz = sb_q.size();
      chk("occ8", {30'b0, occ8}, sz);
      chk("occ16", {30'b0, occ16}, sz);
      chk("occ32", {30'b0, occ32}, sz);
      chk("valid8", {31'b0, out_valid8}, {31'b0, sz != 0});
      chk("valid16", {31'b0, out_valid16}, {31'b0, sz != 0});
      chk("valid32", {31'b0, out_valid32}, {31'b0, sz != 0});
      chk("ready8", {31'b0, in_ready8}, {31'b0, sz < 2});
      chk("ready16", {31'b0, in_ready16}, {31'b0, sz < 2});
      chk("ready32", {31'b0, in_ready32}, {31'b0, sz < 2});
      if (sz != 0) begin
        q0 = sb_q[0];
        chk("data8", {24'b0, out_data8}, {24'b0, q0[7:0]});
        chk("data16", {16'b0, out_data16}, {16'b0, q0[15:0]});
        chk("data32", out_data32, q0);
        if (out_ready) void'(sb_q.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish, got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset();

    // Streaming at full rate, then an asynchronous reset while a beat is held.
    for (int i = 1; i <= 4; i++) cycle(1'b1, i, 1'b1, 1'b0);
    do_reset();

    // Back-pressure: fill, offer a third beat that must be refused, then drain.
    cycle(1'b1, 32'h00A1, 1'b0, 1'b0);
    cycle(1'b1, 32'h00A2, 1'b0, 1'b0);
    cycle(1'b1, 32'h00A3, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // Flush while full with a coincident input; data registers must hold.
    cycle(1'b1, 32'h00B1, 1'b0, 1'b0);
    cycle(1'b1, 32'h00B2, 1'b0, 1'b0);
    cycle(1'b1, 32'h0055, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    chk("flush_hold16", {16'b0, out_data16}, 32'h000000B1);
    chk("flush_valid16", {31'b0, out_valid16}, 32'd0);

    // Simultaneous in/out fire in ONE.
    cycle(1'b1, 32'h0011, 1'b0, 1'b0);
    cycle(1'b1, 32'h0022, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    chk("pass_thru16", {16'b0, out_data16}, 32'h00000022);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // Flush with a coincident out_fire: the outgoing beat still completes.
    cycle(1'b1, 32'h0033, 1'b0, 1'b0);
    cycle(1'b1, 32'h0044, 1'b1, 1'b1);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // Random handshake traffic.
    for (int i = 0; i < 10000; i++) begin
      cycle(($urandom % 4) != 0, $urandom, ($urandom % 3) != 0, ($urandom % 97) == 0);
    end
    repeat (4) cycle(1'b0, 32'h0, 1'b1, 1'b0);
    chk("drained", sb_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
